// File: rtl/uart_mc_pkg.sv
// uart_mc_pkg: shared constants and state encodings for the multi-channel UART port.
// The PARITY states are only visited when UART_MC_PARITY_EN is defined.
package uart_mc_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 8;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_mc_fifo.sv
// uart_mc_fifo: synchronous FIFO with first-word fall-through read data.
// A write while full is only accepted when a read frees a slot in the same cycle.
module uart_mc_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Pointer update; the extra MSB distinguishes full from empty.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset because empty masks them.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_multi_channel_port.sv
// uart_multi_channel_port: CHANNELS independent full-duplex UARTs sharing one
// runtime-programmable 16x oversampling baud generator, with TX/RX byte FIFOs
// and sticky error flags per channel.
// Optional feature: define UART_MC_PARITY_EN to add an even-parity bit to every
// frame and the rx_parity_err output.
module uart_multi_channel_port
  import uart_mc_pkg::*;
#(
  parameter int CHANNELS   = 2,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                           clk,
  input  logic                           rstN,
  input  logic [DIV_WIDTH-1:0]           baud_div,
  input  logic [CHANNELS-1:0]            tx_wr_en,
  input  logic [CHANNELS*DATA_WIDTH-1:0] tx_wr_data,
  output logic [CHANNELS-1:0]            tx_full,
  output logic [CHANNELS-1:0]            tx_busy,
  input  logic [CHANNELS-1:0]            rx_rd_en,
  output logic [CHANNELS*DATA_WIDTH-1:0] rx_rd_data,
  output logic [CHANNELS-1:0]            rx_empty,
  output logic [CHANNELS-1:0]            rx_overflow,
  output logic [CHANNELS-1:0]            rx_frame_err,
`ifdef UART_MC_PARITY_EN
  output logic [CHANNELS-1:0]            rx_parity_err,
`endif
  input  logic [CHANNELS-1:0]            err_clr,
  input  logic [CHANNELS-1:0]            rx,
  output logic [CHANNELS-1:0]            tx
);

  localparam int              BW        = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0]   LAST_BIT  = BW'(DATA_WIDTH - 1);
  localparam logic [3:0]      TICK_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0]      TICK_MID  = 4'(MID_SAMPLE - 1);

  function automatic logic [DIV_WIDTH-1:0] eff_div(input logic [DIV_WIDTH-1:0] d);
    return (d == '0) ? DIV_WIDTH'(1) : d;
  endfunction

  logic [DIV_WIDTH-1:0] baud_cnt;
  logic [DIV_WIDTH-1:0] div_q;
  logic                 tick;

  assign tick = (baud_cnt == div_q - DIV_WIDTH'(1));

  // Shared baud counter; a new divisor is latched only at wrap so periods never get cut short.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      baud_cnt <= '0;
      div_q    <= eff_div(baud_div);
    end else if (tick) begin
      baud_cnt <= '0;
      div_q    <= eff_div(baud_div);
    end else begin
      baud_cnt <= baud_cnt + DIV_WIDTH'(1);
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch

    // ---------------- transmit side ----------------
    tx_state_t             tx_state;
    logic [3:0]            tx_tick;
    logic [BW-1:0]         tx_bit;
    logic [DATA_WIDTH-1:0] tx_shift;
    logic                  tx_q;
    logic                  tx_bit_end;
    logic                  txf_pop;
    logic                  txf_empty;
    logic                  txf_full;
    logic [DATA_WIDTH-1:0] txf_head;
`ifdef UART_MC_PARITY_EN
    logic                  tx_par;
`endif

    assign tx_bit_end = tick && (tx_tick == TICK_LAST);
    assign txf_pop    = !txf_empty &&
                        ((tx_state == TX_IDLE) || ((tx_state == TX_STOP) && tx_bit_end));

    uart_mc_fifo #(
      .WIDTH(DATA_WIDTH),
      .DEPTH(FIFO_DEPTH)
    ) u_tx_fifo (
      .clk    (clk),
      .rstN   (rstN),
      .wr_en  (tx_wr_en[i]),
      .wr_data(tx_wr_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .rd_en  (txf_pop),
      .rd_data(txf_head),
      .full   (txf_full),
      .empty  (txf_empty)
    );

    // Serializer: one bit per 16 ticks; chains straight into the next START when more bytes wait.
    always_ff @(posedge clk) begin
      if (!rstN) begin
        tx_state <= TX_IDLE;
        tx_tick  <= '0;
        tx_bit   <= '0;
        tx_shift <= '0;
        tx_q     <= 1'b1;
`ifdef UART_MC_PARITY_EN
        tx_par   <= 1'b0;
`endif
      end else begin
        if (tick) tx_tick <= tx_tick + 4'd1;
        case (tx_state)
          TX_IDLE: begin
            if (txf_pop) begin
              tx_shift <= txf_head;
              tx_tick  <= '0;
              tx_q     <= 1'b0;
              tx_state <= TX_START;
`ifdef UART_MC_PARITY_EN
              tx_par   <= ^txf_head;
`endif
            end
          end
          TX_START: begin
            if (tx_bit_end) begin
              tx_bit   <= '0;
              tx_q     <= tx_shift[0];
              tx_shift <= tx_shift >> 1;
              tx_state <= TX_DATA;
            end
          end
          TX_DATA: begin
            if (tx_bit_end) begin
              if (tx_bit == LAST_BIT) begin
`ifdef UART_MC_PARITY_EN
                tx_q     <= tx_par;
                tx_state <= TX_PARITY;
`else
                tx_q     <= 1'b1;
                tx_state <= TX_STOP;
`endif
              end else begin
                tx_bit   <= tx_bit + 1'b1;
                tx_q     <= tx_shift[0];
                tx_shift <= tx_shift >> 1;
              end
            end
          end
`ifdef UART_MC_PARITY_EN
          TX_PARITY: begin
            if (tx_bit_end) begin
              tx_q     <= 1'b1;
              tx_state <= TX_STOP;
            end
          end
`endif
          TX_STOP: begin
            if (tx_bit_end) begin
              if (txf_pop) begin
                tx_shift <= txf_head;
                tx_tick  <= '0;
                tx_q     <= 1'b0;
                tx_state <= TX_START;
`ifdef UART_MC_PARITY_EN
                tx_par   <= ^txf_head;
`endif
              end else begin
                tx_state <= TX_IDLE;
              end
            end
          end
          default: begin
            tx_q     <= 1'b1;
            tx_state <= TX_IDLE;
          end
        endcase
      end
    end

    assign tx[i]      = tx_q;
    assign tx_full[i] = txf_full;
    assign tx_busy[i] = (tx_state != TX_IDLE) || !txf_empty;

    // ---------------- receive side ----------------
    logic                  rx_meta;
    logic                  rx_s;
    rx_state_t             rx_state;
    logic [3:0]            rx_tick;
    logic [BW-1:0]         rx_bit;
    logic [DATA_WIDTH-1:0] rx_shift;
    logic                  rx_bit_end;
    logic                  rx_mid;
    logic                  rx_stop_done;
    logic                  rx_par_ok;
    logic                  rx_push;
    logic                  rxf_full;
    logic                  rxf_empty;
    logic                  ovf_set;
    logic                  ferr_set;
    logic                  ovf_q;
    logic                  ferr_q;
`ifdef UART_MC_PARITY_EN
    logic                  rx_par_q;
    logic                  perr_set;
    logic                  perr_q;
    assign rx_par_ok = ((^rx_shift) == rx_par_q);
    assign perr_set  = rx_stop_done && rx_s && !rx_par_ok;
`else
    assign rx_par_ok = 1'b1;
`endif

    assign rx_bit_end   = tick && (rx_tick == TICK_LAST);
    assign rx_mid       = tick && (rx_tick == TICK_MID);
    assign rx_stop_done = (rx_state == RX_STOP) && rx_bit_end;
    assign rx_push      = rx_stop_done && rx_s && rx_par_ok;
    assign ovf_set      = rx_push && rxf_full && !rx_rd_en[i];
    assign ferr_set     = rx_stop_done && !rx_s;

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
      if (!rstN) begin
        rx_meta <= 1'b1;
        rx_s    <= 1'b1;
      end else begin
        rx_meta <= rx[i];
        rx_s    <= rx_meta;
      end
    end

    // Deserializer: confirm the start bit at mid-bit, then sample every 16 ticks from there.
    always_ff @(posedge clk) begin
      if (!rstN) begin
        rx_state <= RX_IDLE;
        rx_tick  <= '0;
        rx_bit   <= '0;
        rx_shift <= '0;
`ifdef UART_MC_PARITY_EN
        rx_par_q <= 1'b0;
`endif
      end else begin
        if (tick) rx_tick <= rx_tick + 4'd1;
        case (rx_state)
          RX_IDLE: begin
            if (!rx_s) begin
              rx_tick  <= '0;
              rx_state <= RX_START;
            end
          end
          RX_START: begin
            if (rx_mid) begin
              if (rx_s) begin
                rx_state <= RX_IDLE;
              end else begin
                rx_tick  <= '0;
                rx_bit   <= '0;
                rx_state <= RX_DATA;
              end
            end
          end
          RX_DATA: begin
            if (rx_bit_end) begin
              rx_shift <= {rx_s, rx_shift[DATA_WIDTH-1:1]};
              if (rx_bit == LAST_BIT) begin
`ifdef UART_MC_PARITY_EN
                rx_state <= RX_PARITY;
`else
                rx_state <= RX_STOP;
`endif
              end else begin
                rx_bit <= rx_bit + 1'b1;
              end
            end
          end
`ifdef UART_MC_PARITY_EN
          RX_PARITY: begin
            if (rx_bit_end) begin
              rx_par_q <= rx_s;
              rx_state <= RX_STOP;
            end
          end
`endif
          RX_STOP: begin
            if (rx_bit_end) rx_state <= RX_IDLE;
          end
          default: rx_state <= RX_IDLE;
        endcase
      end
    end

    uart_mc_fifo #(
      .WIDTH(DATA_WIDTH),
      .DEPTH(FIFO_DEPTH)
    ) u_rx_fifo (
      .clk    (clk),
      .rstN   (rstN),
      .wr_en  (rx_push),
      .wr_data(rx_shift),
      .rd_en  (rx_rd_en[i]),
      .rd_data(rx_rd_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .full   (rxf_full),
      .empty  (rxf_empty)
    );

    // Sticky error flags; a new error in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk) begin
      if (!rstN) begin
        ovf_q  <= 1'b0;
        ferr_q <= 1'b0;
`ifdef UART_MC_PARITY_EN
        perr_q <= 1'b0;
`endif
      end else begin
        if (ovf_set)         ovf_q  <= 1'b1;
        else if (err_clr[i]) ovf_q  <= 1'b0;
        if (ferr_set)        ferr_q <= 1'b1;
        else if (err_clr[i]) ferr_q <= 1'b0;
`ifdef UART_MC_PARITY_EN
        if (perr_set)        perr_q <= 1'b1;
        else if (err_clr[i]) perr_q <= 1'b0;
`endif
      end
    end

    assign rx_empty[i]     = rxf_empty;
    assign rx_overflow[i]  = ovf_q;
    assign rx_frame_err[i] = ferr_q;
`ifdef UART_MC_PARITY_EN
    assign rx_parity_err[i] = perr_q;
`endif

  end : g_ch

endmodule

// File: tb/tb_uart_multi_channel_port.sv
// tb_uart_multi_channel_port: directed self-checking bench for the multi-channel UART
// (CHANNELS=2, FIFO_DEPTH=4). Channel 0 is looped back tx->rx; channel 1's rx is bit-banged.
module tb_uart_multi_channel_port;

  localparam int CH   = 2;
  localparam int DW   = 8;
  localparam int FD   = 4;
  localparam int DIVW = 16;

  logic             clk = 1'b0;
  logic             rstN;
  logic [DIVW-1:0]  baud_div;
  logic [CH-1:0]    tx_wr_en;
  logic [CH*DW-1:0] tx_wr_data;
  logic [CH-1:0]    tx_full;
  logic [CH-1:0]    tx_busy;
  logic [CH-1:0]    rx_rd_en;
  logic [CH*DW-1:0] rx_rd_data;
  logic [CH-1:0]    rx_empty;
  logic [CH-1:0]    rx_overflow;
  logic [CH-1:0]    rx_frame_err;
`ifdef UART_MC_PARITY_EN
  logic [CH-1:0]    rx_parity_err;
`endif
  logic [CH-1:0]    err_clr;
  logic [CH-1:0]    rx;
  logic [CH-1:0]    tx;
  logic             loop_en;
  logic             rx1_drv;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [DIVW-1:0] div;
    logic [7:0]      data;
    logic [7:0]      exp_data;
    int              lat_min;
    int              lat_max;
  } vec_t;

  vec_t       vecs[4];
  logic [7:0] burst[6];

  uart_multi_channel_port #(
    .CHANNELS  (CH),
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(FD),
    .DIV_WIDTH (DIVW)
  ) dut (
    .clk         (clk),
    .rstN        (rstN),
    .baud_div    (baud_div),
    .tx_wr_en    (tx_wr_en),
    .tx_wr_data  (tx_wr_data),
    .tx_full     (tx_full),
    .tx_busy     (tx_busy),
    .rx_rd_en    (rx_rd_en),
    .rx_rd_data  (rx_rd_data),
    .rx_empty    (rx_empty),
    .rx_overflow (rx_overflow),
    .rx_frame_err(rx_frame_err),
`ifdef UART_MC_PARITY_EN
    .rx_parity_err(rx_parity_err),
`endif
    .err_clr     (err_clr),
    .rx          (rx),
    .tx          (tx)
  );

  always #5 clk = ~clk;

  assign rx[0] = loop_en ? tx[0] : 1'b1;
  assign rx[1] = rx1_drv;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pushByte(input int ch, input logic [7:0] data);
    tx_wr_en[ch]             = 1'b1;
    tx_wr_data[ch*DW +: DW]  = data;
    waitCycles(1);
    tx_wr_en[ch]             = 1'b0;
  endtask

  task automatic popByte(input int ch);
    rx_rd_en[ch] = 1'b1;
    waitCycles(1);
    rx_rd_en[ch] = 1'b0;
  endtask

  task automatic waitTxIdle();
    int n = 0;
    while (tx_busy[0] && n < 3000) begin
      waitCycles(1);
      n++;
    end
    checkOutput("tx0_idle_timeout", 32'(tx_busy[0]), 32'd0);
  endtask

  task automatic driveBit1(input logic v, input int n);
    rx1_drv = v;
    waitCycles(n);
  endtask

  // Bit-banged frame on channel 1 at 32 cycles/bit; a low stop bit is held only past mid-bit.
  task automatic sendFrame1(input logic [7:0] data, input logic stop_low);
    driveBit1(1'b0, 32);
    for (int b = 0; b < 8; b++) driveBit1(data[b], 32);
    if (stop_low) begin
      driveBit1(1'b0, 26);
      driveBit1(1'b1, 38);
    end else begin
      driveBit1(1'b1, 64);
    end
  endtask

  // One loopback transaction on channel 0 at the vector's divisor.
  task automatic applyStimulus(input vec_t v, input int idx);
    int lat;
    baud_div = v.div;
    waitCycles(8);
    pushByte(0, v.data);
    lat = 0;
    while (rx_empty[0] && lat < v.lat_max + 40) begin
      waitCycles(1);
      lat++;
    end
    checkOutput($sformatf("vec%0d_latency_in_range(lat=%0d)", idx, lat),
                32'(lat >= v.lat_min && lat <= v.lat_max), 32'd1);
    checkOutput($sformatf("vec%0d_rx0_data", idx), 32'(rx_rd_data[7:0]), 32'(v.exp_data));
    checkOutput($sformatf("vec%0d_rx1_empty", idx), 32'(rx_empty[1]), 32'd1);
    checkOutput($sformatf("vec%0d_rx0_flags", idx), 32'({rx_overflow[0], rx_frame_err[0]}), 32'd0);
    popByte(0);
    checkOutput($sformatf("vec%0d_rx0_empty_after_pop", idx), 32'(rx_empty[0]), 32'd1);
    waitTxIdle();
  endtask

  initial begin
    int run;
    int max_run;
    int dur;
    int n;

    // Latency = cycles from push edge to rx_empty falling: ~4 + 152 ticks of d cycles.
    vecs[0] = '{div: 16'd2, data: 8'hA5, exp_data: 8'hA5, lat_min: 304, lat_max: 314};
    vecs[1] = '{div: 16'd1, data: 8'h00, exp_data: 8'h00, lat_min: 152, lat_max: 162};
    vecs[2] = '{div: 16'd0, data: 8'hFF, exp_data: 8'hFF, lat_min: 152, lat_max: 162};
    vecs[3] = '{div: 16'd3, data: 8'h3C, exp_data: 8'h3C, lat_min: 456, lat_max: 466};
    burst   = '{8'h11, 8'h22, 8'h44, 8'h15, 8'h2A, 8'h55};

    rstN       = 1'b0;
    baud_div   = 16'd2;
    tx_wr_en   = '0;
    tx_wr_data = '0;
    rx_rd_en   = '0;
    err_clr    = '0;
    loop_en    = 1'b1;
    rx1_drv    = 1'b1;
    waitCycles(3);

    checkOutput("reset_tx", 32'(tx), 32'h3);
    checkOutput("reset_tx_full", 32'(tx_full), 32'h0);
    checkOutput("reset_tx_busy", 32'(tx_busy), 32'h0);
    checkOutput("reset_rx_empty", 32'(rx_empty), 32'h3);
    checkOutput("reset_flags", 32'({rx_overflow, rx_frame_err}), 32'h0);
    rstN = 1'b1;
    waitCycles(2);

    $display("[TB] loopback vectors on channel 0");
    for (int i = 0; i < 4; i++) applyStimulus(vecs[i], i);

    $display("[TB] burst of 6 pushes: TX full, back-to-back frames, RX overflow");
    baud_div = 16'd2;
    waitCycles(8);
    for (int k = 0; k < 6; k++) begin
      tx_wr_en[0]         = 1'b1;
      tx_wr_data[DW-1:0]  = burst[k];
      waitCycles(1);
      if (k == 4) checkOutput("burst_tx_full", 32'(tx_full[0]), 32'd1);
    end
    tx_wr_en[0] = 1'b0;
    run = 0;
    max_run = 0;
    dur = 0;
    while (tx_busy[0] && dur < 2500) begin
      if (tx[0]) begin
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      waitCycles(1);
      dur++;
    end
    checkOutput($sformatf("burst_duration_5_frames(dur=%0d)", dur),
                32'(dur >= 1594 && dur <= 1597), 32'd1);
    checkOutput("burst_max_high_run_no_gap", 32'(max_run), 32'd32);
    waitCycles(10);
    checkOutput("burst_rx_overflow", 32'(rx_overflow[0]), 32'd1);
    checkOutput("burst_rx_frame_err", 32'(rx_frame_err[0]), 32'd0);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("burst_rx_not_empty%0d", k), 32'(rx_empty[0]), 32'd0);
      checkOutput($sformatf("burst_rx_data%0d", k), 32'(rx_rd_data[7:0]), 32'(burst[k]));
      popByte(0);
    end
    checkOutput("burst_rx_empty_after_4", 32'(rx_empty[0]), 32'd1);
    checkOutput("burst_overflow_survives_pops", 32'(rx_overflow[0]), 32'd1);
    err_clr[0] = 1'b1;
    waitCycles(1);
    err_clr[0] = 1'b0;
    checkOutput("burst_overflow_cleared", 32'(rx_overflow[0]), 32'd0);

    $display("[TB] channel 1: glitch, good frame, frame error");
    driveBit1(1'b0, 8);
    driveBit1(1'b1, 400);
    checkOutput("glitch_rx1_empty", 32'(rx_empty[1]), 32'd1);
    checkOutput("glitch_rx1_flags", 32'({rx_overflow[1], rx_frame_err[1]}), 32'd0);

    sendFrame1(8'h6B, 1'b0);
    checkOutput("good1_rx1_not_empty", 32'(rx_empty[1]), 32'd0);
    checkOutput("good1_rx1_data", 32'(rx_rd_data[15:8]), 32'h6B);
    checkOutput("good1_rx0_empty", 32'(rx_empty[0]), 32'd1);
    popByte(1);

    sendFrame1(8'h81, 1'b1);
    waitCycles(40);
    checkOutput("ferr_rx1_frame_err", 32'(rx_frame_err[1]), 32'd1);
    checkOutput("ferr_rx1_empty", 32'(rx_empty[1]), 32'd1);
    checkOutput("ferr_rx1_overflow", 32'(rx_overflow[1]), 32'd0);

    $display("[TB] reset in the middle of a frame");
    pushByte(0, 8'h5A);
    waitCycles(100);
    checkOutput("midframe_tx_low_before_reset", 32'(tx[0]), 32'd0);
    rstN = 1'b0;
    waitCycles(1);
    checkOutput("midframe_reset_tx", 32'(tx), 32'h3);
    checkOutput("midframe_reset_flags", 32'({rx_overflow, rx_frame_err}), 32'h0);
    checkOutput("midframe_reset_rx_empty", 32'(rx_empty), 32'h3);
    checkOutput("midframe_reset_tx_busy", 32'(tx_busy), 32'h0);
    rstN = 1'b1;
    waitCycles(4);
    pushByte(0, 8'hC3);
    n = 0;
    while (rx_empty[0] && n < 400) begin
      waitCycles(1);
      n++;
    end
    checkOutput("after_reset_rx_arrived", 32'(rx_empty[0]), 32'd0);
    checkOutput("after_reset_rx_data", 32'(rx_rd_data[7:0]), 32'hC3);
    popByte(0);
    waitTxIdle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
